// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// captures the returned word into the IF/ID register with stall, redirect and halt support.
module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        StStart,
        StRun,
        StHalt
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_pc4_q;
    logic        halted_q;
    logic [31:0] count_q;

    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        is_halt_word;
    logic        count_sat;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign pc_plus4        = pc_q + 32'd4;
    assign is_halt_word    = (imem_data == HALT_WORD);
    assign count_sat       = (count_q == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StStart;
            pc_q     <= PC_RESET;
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            id_pc_q  <= 32'h0;
            id_pc4_q <= 32'h0;
            halted_q <= 1'b0;
            count_q  <= 32'h0;
        end else begin
            unique case (state_q)
                StStart: begin
                    // Bubble cycle; a redirect here still steers the first fetch.
                    valid_q  <= 1'b0;
                    instr_q  <= 32'h0;
                    id_pc_q  <= 32'h0;
                    id_pc4_q <= 32'h0;
                    halted_q <= 1'b0;
                    state_q  <= StRun;
                    if (redirect) begin
                        pc_q <= redirect_target;
                    end
                end
                StRun: begin
                    if (redirect) begin
                        pc_q     <= redirect_target;
                        valid_q  <= 1'b0;
                        instr_q  <= 32'h0;
                        id_pc_q  <= 32'h0;
                        id_pc4_q <= 32'h0;
                    end else if (stall) begin
                        pc_q <= pc_q;
                    end else if (is_halt_word) begin
                        // PC stays on the halt word so a later redirect is the only exit.
                        valid_q  <= 1'b0;
                        instr_q  <= 32'h0;
                        id_pc_q  <= 32'h0;
                        id_pc4_q <= 32'h0;
                        halted_q <= 1'b1;
                        state_q  <= StHalt;
                    end else begin
                        valid_q  <= 1'b1;
                        instr_q  <= imem_data;
                        id_pc_q  <= pc_q;
                        id_pc4_q <= pc_plus4;
                        pc_q     <= pc_plus4;
                        if (!count_sat) begin
                            count_q <= count_q + 32'd1;
                        end
                    end
                end
                StHalt: begin
                    valid_q  <= 1'b0;
                    instr_q  <= 32'h0;
                    id_pc_q  <= 32'h0;
                    id_pc4_q <= 32'h0;
                    if (redirect) begin
                        pc_q     <= redirect_target;
                        halted_q <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                default: begin
                    state_q  <= StStart;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_pc4   = id_pc4_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

    a_bubble_clean : assert property (@(posedge clk) disable iff (!rst_n)
        !valid_q |-> (instr_q == 32'h0 && id_pc_q == 32'h0 && id_pc4_q == 32'h0));

    a_pc4_link : assert property (@(posedge clk) disable iff (!rst_n)
        valid_q |-> (id_pc4_q == id_pc_q + 32'd4));

    a_halt_state : assert property (@(posedge clk) disable iff (!rst_n)
        halted_q == (state_q == StHalt));

endmodule
